// File: rtl/draw_pkg.sv
// Shared constants and helpers for the Arkanoid renderers (ball, brick, paddle).
package draw_pkg;

    localparam int unsigned SHAPE_DISC = 0;
    localparam int unsigned SHAPE_RING = 1;

    localparam int unsigned DEF_CNT  = 3;
    localparam int unsigned DEF_HW   = 12;
    localparam int unsigned DEF_VW   = 11;
    localparam int unsigned DEF_PW   = 10;
    localparam int unsigned DEF_RW   = 6;
    localparam int unsigned DEF_COLW = 3;

    // Index width for n objects: clog2 with a floor of one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Signed width able to hold any pixel-minus-centre difference.
    function automatic int unsigned diff_width(input int unsigned hw, input int unsigned vw);
        return ((hw > vw) ? hw : vw) + 2;
    endfunction

endpackage

// File: rtl/draw_ball_pipe_if.sv
// Pixel/ball-state bus between the VGA timing path and the ball renderer.
interface draw_ball_pipe_if
    import draw_pkg::*;
#(
    parameter int unsigned CNT  = DEF_CNT,
    parameter int unsigned HW   = DEF_HW,
    parameter int unsigned VW   = DEF_VW,
    parameter int unsigned PW   = DEF_PW,
    parameter int unsigned RW   = DEF_RW,
    parameter int unsigned COLW = DEF_COLW
);
    localparam int unsigned IW = idx_width(CNT);

    logic                  frame_start;
    logic                  pix_valid;
    logic [HW-1:0]         hcounter;
    logic [VW-1:0]         vcounter;
    logic [CNT*PW-1:0]     xs;
    logic [CNT*PW-1:0]     ys;
    logic [CNT*RW-1:0]     sizes;
    logic [CNT*COLW-1:0]   colors;
    logic [CNT-1:0]        balls;
    logic                  out_valid;
    logic                  v;
    logic [COLW-1:0]       rgb;
    logic [IW-1:0]         hit_idx;

    modport master (
        output frame_start, pix_valid, hcounter, vcounter, xs, ys, sizes, colors, balls,
        input  out_valid, v, rgb, hit_idx
    );

    modport slave (
        input  frame_start, pix_valid, hcounter, vcounter, xs, ys, sizes, colors, balls,
        output out_valid, v, rgb, hit_idx
    );

endinterface

// File: rtl/draw_ball_pipe_dist.sv
// Per-ball distance pipeline: stage 1 differences/radii, stage 2 squared distance.
module ball_dist_pipe
    import draw_pkg::*;
#(
    parameter int unsigned HW = DEF_HW,
    parameter int unsigned VW = DEF_VW,
    parameter int unsigned PW = DEF_PW,
    parameter int unsigned RW = DEF_RW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [HW-1:0]             i_h,
    input  logic [VW-1:0]             i_v,
    input  logic [PW-1:0]             i_x,
    input  logic [PW-1:0]             i_y,
    input  logic [RW-1:0]             i_size,
    output logic [2*diff_width(HW, VW)-1:0] o_d2,
    output logic [2*RW-1:0]           o_r2,
    output logic signed [2*RW:0]      o_inner
);
    localparam int unsigned CW  = diff_width(HW, VW);
    localparam int unsigned D2W = 2 * CW;

    logic signed [CW-1:0]   w_dx, w_dy;
    logic [RW-1:0]          w_size_m1;
    logic [2*RW-1:0]        w_r2, w_inner_sq;
    logic signed [2*RW:0]   w_inner;

    logic signed [CW-1:0]   r_dx, r_dy;
    logic [2*RW-1:0]        r_r2;
    logic signed [2*RW:0]   r_inner;

    logic signed [D2W-1:0]  w_dx_ext, w_dy_ext, w_dx2, w_dy2;
    logic [D2W-1:0]         w_d2;

    logic [D2W-1:0]         r_d2;
    logic [2*RW-1:0]        r_r2_p2;
    logic signed [2*RW:0]   r_inner_p2;

    // Stage 1 arithmetic: zero-extended operands give signed, non-wrapping differences.
    always_comb begin
        w_dx       = $signed(CW'(i_h)) - $signed(CW'(i_x));
        w_dy       = $signed(CW'(i_v)) - $signed(CW'(i_y));
        w_size_m1  = i_size - RW'(1);
        w_r2       = (2*RW)'(i_size) * (2*RW)'(i_size);
        w_inner_sq = (2*RW)'(w_size_m1) * (2*RW)'(w_size_m1);
        w_inner    = (i_size != '0) ? $signed({1'b0, w_inner_sq}) : '1;
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx    <= '0;
            r_dy    <= '0;
            r_r2    <= '0;
            r_inner <= '0;
        end else begin
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_r2    <= w_r2;
            r_inner <= w_inner;
        end
    end

    // Stage 2 arithmetic: full-width sum of squares.
    always_comb begin
        w_dx_ext = {{CW{r_dx[CW-1]}}, r_dx};
        w_dy_ext = {{CW{r_dy[CW-1]}}, r_dy};
        w_dx2    = w_dx_ext * w_dx_ext;
        w_dy2    = w_dy_ext * w_dy_ext;
        w_d2     = $unsigned(w_dx2) + $unsigned(w_dy2);
    end

    // Stage 2 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d2       <= '0;
            r_r2_p2    <= '0;
            r_inner_p2 <= '0;
        end else begin
            r_d2       <= w_d2;
            r_r2_p2    <= r_r2;
            r_inner_p2 <= r_inner;
        end
    end

    assign o_d2    = r_d2;
    assign o_r2    = r_r2_p2;
    assign o_inner = r_inner_p2;

endmodule

// File: rtl/draw_ball_pipe.sv
// Three-stage ball renderer: frame-snapshotted ball state, per-ball distance, priority mux.
module draw_ball_pipe
    import draw_pkg::*;
#(
    parameter int unsigned CNT   = DEF_CNT,
    parameter int unsigned HW    = DEF_HW,
    parameter int unsigned VW    = DEF_VW,
    parameter int unsigned PW    = DEF_PW,
    parameter int unsigned RW    = DEF_RW,
    parameter int unsigned COLW  = DEF_COLW,
    parameter int unsigned SHAPE = SHAPE_DISC
) (
    input  logic            clk,
    input  logic            rst,
    draw_ball_pipe_if.slave bus
);
    localparam int unsigned IW  = idx_width(CNT);
    localparam int unsigned D2W = 2 * diff_width(HW, VW);

    logic [CNT*PW-1:0]    r_xs, r_ys;
    logic [CNT*RW-1:0]    r_sizes;
    logic [CNT*COLW-1:0]  r_colors;
    logic [CNT-1:0]       r_balls;

    logic [1:0]           r_vld;
    logic [CNT-1:0]       r_en_p1, r_en_p2;
    logic [CNT*COLW-1:0]  r_col_p1, r_col_p2;

    logic [D2W-1:0]        w_d2    [CNT];
    logic [2*RW-1:0]       w_r2    [CNT];
    logic signed [2*RW:0]  w_inner [CNT];

    logic                 w_any;
    logic [IW-1:0]        w_idx;
    logic [COLW-1:0]      w_rgb;

    logic                 r_out_valid, r_v;
    logic [COLW-1:0]      r_rgb;
    logic [IW-1:0]        r_hit_idx;

    // Shadow ball state, refreshed only on frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xs     <= '0;
            r_ys     <= '0;
            r_sizes  <= '0;
            r_colors <= '0;
            r_balls  <= '0;
        end else if (bus.frame_start) begin
            r_xs     <= bus.xs;
            r_ys     <= bus.ys;
            r_sizes  <= bus.sizes;
            r_colors <= bus.colors;
            r_balls  <= bus.balls;
        end
    end

    // Valid bits plus enables/colours that travel with each pixel, so a mid-flight snapshot cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_en_p1  <= '0;
            r_en_p2  <= '0;
            r_col_p1 <= '0;
            r_col_p2 <= '0;
        end else begin
            r_vld    <= {r_vld[0], bus.pix_valid};
            r_en_p1  <= r_balls;
            r_en_p2  <= r_en_p1;
            r_col_p1 <= r_colors;
            r_col_p2 <= r_col_p1;
        end
    end

    // One distance pipeline per ball.
    for (genvar g = 0; g < CNT; g++) begin : g_ball
        ball_dist_pipe #(.HW(HW), .VW(VW), .PW(PW), .RW(RW)) u_dist (
            .clk     (clk),
            .rst     (rst),
            .i_h     (bus.hcounter),
            .i_v     (bus.vcounter),
            .i_x     (r_xs[g*PW +: PW]),
            .i_y     (r_ys[g*PW +: PW]),
            .i_size  (r_sizes[g*RW +: RW]),
            .o_d2    (w_d2[g]),
            .o_r2    (w_r2[g]),
            .o_inner (w_inner[g])
        );
    end

    // Stage 3 hit test; scanning downward lets the lowest hitting index win.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_rgb = '0;
        for (int i = int'(CNT) - 1; i >= 0; i--) begin
            logic                 l_le, l_gt;
            logic signed [D2W:0]  l_inner_ext;
            l_inner_ext = {{(D2W-2*RW){w_inner[i][2*RW]}}, w_inner[i]};
            l_le        = w_d2[i] <= D2W'(w_r2[i]);
            l_gt        = $signed({1'b0, w_d2[i]}) > l_inner_ext;
            if (r_en_p2[i] && l_le && ((SHAPE != SHAPE_RING) || l_gt)) begin
                w_any = 1'b1;
                w_idx = IW'(i);
                w_rgb = r_col_p2[i*COLW +: COLW];
            end
        end
    end

    // Output registers; pixel outputs are held at zero whenever out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_v         <= 1'b0;
            r_rgb       <= '0;
            r_hit_idx   <= '0;
        end else begin
            r_out_valid <= r_vld[1];
            r_v         <= r_vld[1] & w_any;
            r_rgb       <= r_vld[1] ? w_rgb : '0;
            r_hit_idx   <= r_vld[1] ? w_idx : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.v         = r_v;
    assign bus.rgb       = r_rgb;
    assign bus.hit_idx   = r_hit_idx;

endmodule

// File: tb/tb_draw_ball_pipe.sv
// Directed bench: a disc renderer and a ring renderer fed from the same stimulus.
module tb_draw_ball_pipe;
    import draw_pkg::*;

    localparam int unsigned CNT = 3, HW = 12, VW = 11, PW = 10, RW = 6, COLW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                frame_start = 1'b0;
    logic                pix_valid   = 1'b0;
    logic [HW-1:0]       hc = '0;
    logic [VW-1:0]       vc = '0;
    logic [CNT*PW-1:0]   xs = '0;
    logic [CNT*PW-1:0]   ys = '0;
    logic [CNT*RW-1:0]   sizes = '0;
    logic [CNT*COLW-1:0] colors = '0;
    logic [CNT-1:0]      balls = '0;

    int errors = 0;
    int checks = 0;

    draw_ball_pipe_if #(.CNT(CNT), .HW(HW), .VW(VW), .PW(PW), .RW(RW), .COLW(COLW)) bus_d ();
    draw_ball_pipe_if #(.CNT(CNT), .HW(HW), .VW(VW), .PW(PW), .RW(RW), .COLW(COLW)) bus_r ();

    assign bus_d.frame_start = frame_start;
    assign bus_d.pix_valid   = pix_valid;
    assign bus_d.hcounter    = hc;
    assign bus_d.vcounter    = vc;
    assign bus_d.xs          = xs;
    assign bus_d.ys          = ys;
    assign bus_d.sizes       = sizes;
    assign bus_d.colors      = colors;
    assign bus_d.balls       = balls;
    assign bus_r.frame_start = frame_start;
    assign bus_r.pix_valid   = pix_valid;
    assign bus_r.hcounter    = hc;
    assign bus_r.vcounter    = vc;
    assign bus_r.xs          = xs;
    assign bus_r.ys          = ys;
    assign bus_r.sizes       = sizes;
    assign bus_r.colors      = colors;
    assign bus_r.balls       = balls;

    draw_ball_pipe #(.CNT(CNT), .HW(HW), .VW(VW), .PW(PW), .RW(RW), .COLW(COLW), .SHAPE(SHAPE_DISC))
        u_disc (.clk(clk), .rst(rst), .bus(bus_d));
    draw_ball_pipe #(.CNT(CNT), .HW(HW), .VW(VW), .PW(PW), .RW(RW), .COLW(COLW), .SHAPE(SHAPE_RING))
        u_ring (.clk(clk), .rst(rst), .bus(bus_r));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ball(input int i, input int x, input int y, input int r, input int col);
        xs[i*PW +: PW]         = PW'(x);
        ys[i*PW +: PW]         = PW'(y);
        sizes[i*RW +: RW]      = RW'(r);
        colors[i*COLW +: COLW] = COLW'(col);
    endtask

    task automatic load();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    // Single pixel; checks out_valid low one cycle early, then the result exactly 3 cycles later.
    task automatic probe(input string tag, input int h, input int vv);
        @(negedge clk);
        pix_valid = 1'b1; hc = HW'(h); vc = VW'(vv);
        @(negedge clk) pix_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(bus_d.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_ov"}, 32'(bus_d.out_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ov", 32'(bus_d.out_valid), 32'd0);
        chk("rst_v", 32'(bus_d.v), 32'd0);
        chk("rst_rgb", 32'(bus_d.rgb), 32'd0);
        chk("rst_idx", 32'(bus_d.hit_idx), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Nothing drawn before first frame_start, even though live inputs describe a ball
        set_ball(0, 100, 100, 5, 7); balls = 3'b001;
        probe("nofs", 100, 100);
        chk("nofs_v", 32'(bus_d.v), 32'd0);
        chk("nofs_rgb", 32'(bus_d.rgb), 32'd0);

        // Disc radius 5 at (100,100)
        load();
        probe("d1", 104, 103);
        chk("d1_v", 32'(bus_d.v), 32'd1);
        chk("d1_rgb", 32'(bus_d.rgb), 32'd7);
        chk("d1_idx", 32'(bus_d.hit_idx), 32'd0);
        probe("d2", 105, 101);
        chk("d2_v", 32'(bus_d.v), 32'd0);
        chk("d2_rgb", 32'(bus_d.rgb), 32'd0);
        probe("d3", 100, 95);
        chk("d3_v", 32'(bus_d.v), 32'd1);
        chk("d3_rgb", 32'(bus_d.rgb), 32'd7);

        // Overlap: lower index wins; disabled ball never hits
        set_ball(0, 50, 50, 10, 1);
        set_ball(1, 52, 50, 10, 2);
        set_ball(2, 55, 50, 10, 4);
        balls = 3'b101;
        load();
        probe("ov0", 52, 50);
        chk("ov0_v", 32'(bus_d.v), 32'd1);
        chk("ov0_idx", 32'(bus_d.hit_idx), 32'd0);
        chk("ov0_rgb", 32'(bus_d.rgb), 32'd1);
        balls = 3'b100;
        load();
        probe("ov2", 52, 50);
        chk("ov2_v", 32'(bus_d.v), 32'd1);
        chk("ov2_idx", 32'(bus_d.hit_idx), 32'd2);
        chk("ov2_rgb", 32'(bus_d.rgb), 32'd4);

        // Ring radius 4 at (200,200): only 9 < d2 <= 16 lit
        set_ball(0, 200, 200, 4, 5); balls = 3'b001;
        load();
        probe("rg1", 204, 200);
        chk("rg1_v", 32'(bus_r.v), 32'd1);
        chk("rg1_rgb", 32'(bus_r.rgb), 32'd5);
        probe("rg2", 203, 200);
        chk("rg2_v", 32'(bus_r.v), 32'd0);
        chk("rg2_disc_v", 32'(bus_d.v), 32'd1);
        probe("rg3", 200, 200);
        chk("rg3_v", 32'(bus_r.v), 32'd0);
        chk("rg3_disc_v", 32'(bus_d.v), 32'd1);

        // Radius 0: centre pixel only, disc and ring alike
        set_ball(0, 200, 200, 0, 5);
        load();
        probe("r0c", 200, 200);
        chk("r0c_ring_v", 32'(bus_r.v), 32'd1);
        chk("r0c_disc_v", 32'(bus_d.v), 32'd1);
        probe("r0n", 201, 200);
        chk("r0n_ring_v", 32'(bus_r.v), 32'd0);
        chk("r0n_disc_v", 32'(bus_d.v), 32'd0);

        // Near the top-left edge: d2 = 8 <= 25
        set_ball(0, 2, 2, 5, 6);
        load();
        probe("edge", 0, 0);
        chk("edge_v", 32'(bus_d.v), 32'd1);
        chk("edge_rgb", 32'(bus_d.rgb), 32'd6);
        xs[0 +: PW] = PW'(500);
        probe("live", 0, 0);
        chk("live_v", 32'(bus_d.v), 32'd1);

        // frame_start coincident with a pixel: that pixel old shadow, next pixel new shadow
        @(negedge clk);
        frame_start = 1'b1; pix_valid = 1'b1; hc = '0; vc = '0;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) pix_valid = 1'b0;
        @(negedge clk);
        chk("fs_old_v", 32'(bus_d.v), 32'd1);
        @(negedge clk);
        chk("fs_new_ov", 32'(bus_d.out_valid), 32'd1);
        chk("fs_new_v", 32'(bus_d.v), 32'd0);

        // Toggling pix_valid stream at (500,2), then async reset mid-stream
        hc = HW'(500); vc = VW'(2);
        @(negedge clk) pix_valid = 1'b1;
        @(negedge clk) pix_valid = 1'b0;
        @(negedge clk) pix_valid = 1'b1;
        @(negedge clk) pix_valid = 1'b1;
        chk("st0_ov", 32'(bus_d.out_valid), 32'd1);
        chk("st0_v", 32'(bus_d.v), 32'd1);
        @(negedge clk) pix_valid = 1'b0;
        chk("st1_ov", 32'(bus_d.out_valid), 32'd0);
        chk("st1_v", 32'(bus_d.v), 32'd0);
        @(negedge clk);
        chk("st2_ov", 32'(bus_d.out_valid), 32'd1);
        chk("st2_v", 32'(bus_d.v), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", 32'(bus_d.out_valid), 32'd0);
        chk("arst_v", 32'(bus_d.v), 32'd0);
        chk("arst_idx", 32'(bus_d.hit_idx), 32'd0);
        @(negedge clk) rst = 1'b0;
        probe("post", 500, 2);
        chk("post_v", 32'(bus_d.v), 32'd0);
        load();
        probe("reload", 500, 2);
        chk("reload_v", 32'(bus_d.v), 32'd1);
        chk("reload_rgb", 32'(bus_d.rgb), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
